// File: rtl/mc68000_mem_slave.sv
// MC68000 asynchronous-bus memory slave: 16-bit word RAM window with
// programmable wait states, byte-lane strobes and bus-error on decode miss.
module mc68000_mem_slave #(
    parameter logic [23:0] BASE_ADDR   = 24'h000000,
    parameter int          DEPTH_LOG2  = 8,
    parameter int          WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [23:0] a,
    inout  wire  [15:0] d,
    input  logic        as_n,
    input  logic        rw_n,
    input  logic        uds_n,
    input  logic        lds_n,
    output logic        dtack_n,
    output logic        berr_n
);

    localparam int          DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [24:0] WIN_BYTES = 25'(1) << (DEPTH_LOG2 + 1);
    localparam logic [3:0]  WS        = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK,
        S_BERR
    } state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] idx_q, idx_d;
    logic                  rw_n_q, rw_n_d;
    logic                  uds_n_q, uds_n_d;
    logic                  lds_n_q, lds_n_d;
    logic                  dtack_n_q, dtack_n_d;
    logic                  berr_n_q, berr_n_d;

    logic [15:0]           mem [DEPTH];
    logic [15:0]           rdata;
    logic [23:0]           off;
    logic                  hit;
    logic                  req;
    logic                  wr_en;
    logic                  drv;

    assign off = a - BASE_ADDR;
    assign hit = (a >= BASE_ADDR) && ({1'b0, off} < WIN_BYTES);
    assign req = !as_n && (!uds_n || !lds_n);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        rw_n_d  = rw_n_q;
        uds_n_d = uds_n_q;
        lds_n_d = lds_n_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d   = off[DEPTH_LOG2:1];
                    rw_n_d  = rw_n;
                    uds_n_d = uds_n;
                    lds_n_d = lds_n;
                    if (hit) begin
                        state_d = S_WAIT;
                        cnt_d   = WS;
                    end else begin
                        state_d = S_BERR;
                    end
                end
            end
            // Master dropping as_n here aborts the cycle before any commit.
            S_WAIT: begin
                if (as_n) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd0) begin
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACK: begin
                if (as_n) state_d = S_IDLE;
            end
            S_BERR: begin
                if (as_n) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        dtack_n_d = (state_d != S_ACK);
        berr_n_d  = (state_d != S_BERR);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            idx_q     <= '0;
            rw_n_q    <= 1'b1;
            uds_n_q   <= 1'b1;
            lds_n_q   <= 1'b1;
            dtack_n_q <= 1'b1;
            berr_n_q  <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            rw_n_q    <= rw_n_d;
            uds_n_q   <= uds_n_d;
            lds_n_q   <= lds_n_d;
            dtack_n_q <= dtack_n_d;
            berr_n_q  <= berr_n_d;
        end
    end

    // Commit happens only on the single WAIT->ACK edge of a write.
    assign wr_en = reset_n && (state_q == S_WAIT) && (cnt_q == 4'd0)
                   && !as_n && !rw_n_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!uds_n_q) mem[idx_q][15:8] <= d[15:8];
            if (!lds_n_q) mem[idx_q][7:0]  <= d[7:0];
        end
    end

    assign rdata = mem[idx_q];
    assign drv   = ((state_q == S_WAIT) || (state_q == S_ACK)) && rw_n_q;

    assign d[15:8] = (drv && !uds_n_q) ? rdata[15:8] : 8'hzz;
    assign d[7:0]  = (drv && !lds_n_q) ? rdata[7:0]  : 8'hzz;

    assign dtack_n = dtack_n_q;
    assign berr_n  = berr_n_q;

endmodule

// File: tb/tb_mc68000_mem_slave.sv
// Bench for mc68000_mem_slave: bus-master tasks with a read-data scoreboard,
// one instance at default wait states and one with zero wait states.
module tb_mc68000_mem_slave;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [23:0] a = '0;
    logic        as_n = 1'b1;
    logic        as0_n = 1'b1;
    logic        rw_n = 1'b1;
    logic        uds_n = 1'b1;
    logic        lds_n = 1'b1;
    logic        oe = 1'b0;
    logic [15:0] wd = '0;
    tri1  [15:0] d;
    tri1  [15:0] d0;
    logic        dtack_n, berr_n;
    logic        dtack0_n, berr0_n;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_q [$];

    assign d  = oe ? wd : 16'hzzzz;
    assign d0 = oe ? wd : 16'hzzzz;

    always #5 clk = ~clk;

    mc68000_mem_slave dut (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (a),
        .d       (d),
        .as_n    (as_n),
        .rw_n    (rw_n),
        .uds_n   (uds_n),
        .lds_n   (lds_n),
        .dtack_n (dtack_n),
        .berr_n  (berr_n)
    );

    mc68000_mem_slave #(.WAIT_STATES(0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (a),
        .d       (d0),
        .as_n    (as0_n),
        .rw_n    (rw_n),
        .uds_n   (uds_n),
        .lds_n   (lds_n),
        .dtack_n (dtack0_n),
        .berr_n  (berr0_n)
    );

    // lat = posedges after the request edge until dtack/berr seen (0 = none)
    task automatic bus(input bit u0, input logic [23:0] addr, input bit rw,
                       input bit ud, input bit ld, input logic [15:0] wdat,
                       input int abort_after, output int lat,
                       output bit berr, output logic [15:0] rd);
        @(negedge clk);
        a = addr;
        rw_n = rw;
        uds_n = ud;
        lds_n = ld;
        wd = wdat;
        oe = !rw;
        if (u0) as0_n = 1'b0;
        else as_n = 1'b0;
        @(posedge clk);
        lat = 0;
        berr = 1'b0;
        rd = '0;
        for (int k = 1; k <= 32; k++) begin
            if (abort_after == k) begin
                @(negedge clk);
                as_n = 1'b1;
                as0_n = 1'b1;
            end
            @(posedge clk);
            #1;
            if ((u0 ? dtack0_n : dtack_n) == 1'b0 ||
                (u0 ? berr0_n : berr_n) == 1'b0) begin
                lat = k;
                berr = ((u0 ? berr0_n : berr_n) == 1'b0);
                rd = u0 ? d0 : d;
                break;
            end
            if (abort_after != 0 && k >= abort_after + 3) break;
        end
        @(negedge clk);
        as_n = 1'b1;
        as0_n = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        oe = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if (dtack_n !== 1'b1 || berr_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_outputs: dtack_n=%b berr_n=%b required 1 1",
                     dtack_n, berr_n);
        end
        n_checks++;
        if (d !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL reset_bus_hiz: d=%h required released (FFFF)", d);
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_word();
        int lat;
        bit be;
        logic [15:0] rd;
        bus(0, 24'h000010, 0, 0, 0, 16'h1234, 0, lat, be, rd);
        n_checks++;
        if (lat != 3 || be) begin
            n_fail++;
            $display("FAIL word_write_lat: lat=%0d berr=%b required 3 0",
                     lat, be);
        end
        exp_q.push_back(16'h1234);
        bus(0, 24'h000010, 1, 0, 0, 16'h0, 0, lat, be, rd);
        n_checks++;
        if (lat != 3 || be) begin
            n_fail++;
            $display("FAIL word_read_lat: lat=%0d berr=%b required 3 0",
                     lat, be);
        end
        n_checks++;
        if (rd !== exp_q[0]) begin
            n_fail++;
            $display("FAIL word_read_data: d=%h required %h", rd, exp_q[0]);
        end
        void'(exp_q.pop_front());
        n_checks++;
        if (dtack_n !== 1'b1 || d !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL word_release: dtack_n=%b d=%h required 1 FFFF",
                     dtack_n, d);
        end
    endtask

    task automatic test_lanes();
        int lat;
        bit be;
        logic [15:0] rd;
        bus(0, 24'h000020, 0, 0, 1, 16'hAB00, 0, lat, be, rd);
        bus(0, 24'h000020, 0, 1, 0, 16'h00CD, 0, lat, be, rd);
        exp_q.push_back(16'hABCD);
        bus(0, 24'h000020, 1, 0, 0, 16'h0, 0, lat, be, rd);
        n_checks++;
        if (rd !== exp_q[0]) begin
            n_fail++;
            $display("FAIL lanes_word: d=%h required %h", rd, exp_q[0]);
        end
        void'(exp_q.pop_front());
        exp_q.push_back(16'hFFCD);
        bus(0, 24'h000021, 1, 1, 0, 16'h0, 0, lat, be, rd);
        n_checks++;
        if (rd !== exp_q[0] || lat != 3) begin
            n_fail++;
            $display("FAIL lanes_lower_only: d=%h lat=%0d required %h 3",
                     rd, lat, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_miss();
        int lat;
        bit be;
        logic [15:0] rd;
        bus(0, 24'h0001FE, 0, 0, 0, 16'hC3A5, 0, lat, be, rd);
        exp_q.push_back(16'hC3A5);
        bus(0, 24'h0001FE, 1, 0, 0, 16'h0, 0, lat, be, rd);
        n_checks++;
        if (rd !== exp_q[0] || be) begin
            n_fail++;
            $display("FAIL last_word: d=%h berr=%b required %h 0",
                     rd, be, exp_q[0]);
        end
        void'(exp_q.pop_front());
        bus(0, 24'h000200, 1, 0, 0, 16'h0, 0, lat, be, rd);
        n_checks++;
        if (!be || lat != 1) begin
            n_fail++;
            $display("FAIL miss_berr: berr=%b lat=%0d required 1 1", be, lat);
        end
        n_checks++;
        if (dtack_n !== 1'b1 || berr_n !== 1'b1) begin
            n_fail++;
            $display("FAIL miss_release: dtack_n=%b berr_n=%b required 1 1",
                     dtack_n, berr_n);
        end
    endtask

    task automatic test_strobe_wait();
        @(negedge clk);
        a = 24'h000200;
        rw_n = 1'b0;
        as_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (berr_n !== 1'b1 || dtack_n !== 1'b1) begin
            n_fail++;
            $display("FAIL no_strobe_idle: berr_n=%b dtack_n=%b required 1 1",
                     berr_n, dtack_n);
        end
        @(negedge clk);
        as_n = 1'b1;
        rw_n = 1'b1;
        @(posedge clk);
    endtask

    task automatic test_abort();
        int lat;
        bit be;
        logic [15:0] rd;
        bus(0, 24'h000004, 0, 0, 0, 16'h0055, 0, lat, be, rd);
        bus(0, 24'h000004, 0, 0, 0, 16'hFFFF, 2, lat, be, rd);
        n_checks++;
        if (lat != 0) begin
            n_fail++;
            $display("FAIL abort_no_dtack: ack at %0d required none", lat);
        end
        exp_q.push_back(16'h0055);
        bus(0, 24'h000004, 1, 0, 0, 16'h0, 0, lat, be, rd);
        n_checks++;
        if (rd !== exp_q[0]) begin
            n_fail++;
            $display("FAIL abort_readback: d=%h required %h", rd, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_mid_reset();
        int lat;
        bit be;
        logic [15:0] rd;
        @(negedge clk);
        a = 24'h000010;
        rw_n = 1'b1;
        uds_n = 1'b0;
        lds_n = 1'b0;
        as_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (dtack_n !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_ack: dtack_n=%b required 0", dtack_n);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (dtack_n !== 1'b1 || d !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL mid_reset_async: dtack_n=%b d=%h required 1 FFFF",
                     dtack_n, d);
        end
        @(negedge clk);
        as_n = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(16'h1234);
        bus(0, 24'h000010, 1, 0, 0, 16'h0, 0, lat, be, rd);
        n_checks++;
        if (rd !== exp_q[0] || lat != 3) begin
            n_fail++;
            $display("FAIL mid_reset_read: d=%h lat=%0d required %h 3",
                     rd, lat, exp_q[0]);
        end
        void'(exp_q.pop_front());
        bus(0, 24'h000030, 0, 0, 0, 16'h1111, 0, lat, be, rd);
        @(negedge clk);
        a = 24'h000030;
        rw_n = 1'b0;
        wd = 16'h2222;
        oe = 1'b1;
        uds_n = 1'b0;
        lds_n = 1'b0;
        as_n = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b0;
        @(negedge clk);
        as_n = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
        oe = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(16'h1111);
        bus(0, 24'h000030, 1, 0, 0, 16'h0, 0, lat, be, rd);
        n_checks++;
        if (rd !== exp_q[0]) begin
            n_fail++;
            $display("FAIL reset_write_abandon: d=%h required %h",
                     rd, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    task automatic test_back_to_back();
        int lat;
        bit be;
        logic [15:0] rd;
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 16'($urandom);
            bus(0, 24'h000040 + 24'(2 * i), 0, 0, 0, v, 0, lat, be, rd);
            exp_q.push_back(v);
        end
        for (int i = 0; i < 8; i++) begin
            bus(0, 24'h000040 + 24'(2 * i), 1, 0, 0, 16'h0, 0, lat, be, rd);
            n_checks++;
            if (rd !== exp_q[0] || lat != 3) begin
                n_fail++;
                $display("FAIL b2b_read[%0d]: d=%h lat=%0d required %h 3",
                         i, rd, lat, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_ws0();
        int lat;
        bit be;
        logic [15:0] rd;
        bus(1, 24'h000010, 0, 0, 0, 16'hBEEF, 0, lat, be, rd);
        n_checks++;
        if (lat != 1) begin
            n_fail++;
            $display("FAIL ws0_write_lat: lat=%0d required 1", lat);
        end
        exp_q.push_back(16'hBEEF);
        bus(1, 24'h000010, 1, 0, 0, 16'h0, 0, lat, be, rd);
        n_checks++;
        if (lat != 1 || rd !== exp_q[0]) begin
            n_fail++;
            $display("FAIL ws0_read: lat=%0d d=%h required 1 %h",
                     lat, rd, exp_q[0]);
        end
        void'(exp_q.pop_front());
    endtask

    initial begin
        test_reset();
        test_word();
        test_lanes();
        test_miss();
        test_strobe_wait();
        test_abort();
        test_mid_reset();
        test_back_to_back();
        test_ws0();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
